// File: rtl/pcode_chip_seq.sv
// pcode_chip_seq: drives the pcode ROM address at an NCO chip rate and emits the selected ROM bit as a chip stream.
// Ports:
//   clk, rst         clock, asynchronous active-low reset
//   en               run enable, gates the chip NCO
//   fcw              chip-rate frequency control word
//   phase_load       pulse loading phase_init as the code phase (wins over a tick)
//   phase_init       chip index to load; out-of-range values load 0 and flag phase_err
//   chan_sel         which of the 8 ROM bits becomes the chip
//   pcode_in         ROM data, valid ROM_LAT cycles after pcode_addr changes
//   pcode_addr       registered ROM address
//   chip_out         registered chip, held between strobes
//   chip_valid       strobe: chip_out updated
//   epoch            strobe with chip_valid of chip index 0
//   phase_err        sticky out-of-range load flag
module pcode_chip_seq #(
   parameter int CODE_LEN = 20460,
   parameter int ADDR_W   = 16,
   parameter int NCO_W    = 32,
   parameter int ROM_LAT  = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [NCO_W-1:0]  fcw,
   input  logic              phase_load,
   input  logic [ADDR_W-1:0] phase_init,
   input  logic [2:0]        chan_sel,
   input  logic [7:0]        pcode_in,
   output logic [ADDR_W-1:0] pcode_addr,
   output logic              chip_out,
   output logic              chip_valid,
   output logic              epoch,
   output logic              phase_err
);
   localparam int P = ROM_LAT + 1;
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(CODE_LEN - 1);
   logic [NCO_W-1:0]  acc_q, acc_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [P-1:0]      v_q, v_d, z_q, z_d;
   logic              chip_q, chip_d, valid_q, valid_d, epoch_q, epoch_d, err_q, err_d;
   logic [NCO_W:0]    sum;
   logic              tick, bad;
   // v/z pipeline: stage 0 is visible while the issued address is on pcode_addr,
   // stage ROM_LAT lines up with that address's data on pcode_in.
   always_comb begin
      sum     = {1'b0, acc_q} + {1'b0, fcw};
      tick    = en & sum[NCO_W];
      bad     = phase_init > LAST;
      acc_d   = phase_load ? '0 : en ? sum[NCO_W-1:0] : acc_q;
      addr_d  = phase_load ? (bad ? '0 : phase_init)
              : !tick ? addr_q
              : addr_q == LAST ? '0 : addr_q + ADDR_W'(1);
      err_d   = phase_load ? bad : err_q;
      v_d     = phase_load ? P'(1) : {v_q[P-2:0], tick};
      z_d     = {z_q[P-2:0], addr_d == '0};
      valid_d = v_q[P-1] & ~phase_load;
      epoch_d = valid_d & z_q[P-1];
      chip_d  = valid_d ? pcode_in[chan_sel] : chip_q;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_q   <= '0;
         addr_q  <= '0;
         v_q     <= '0;
         z_q     <= '0;
         chip_q  <= 1'b0;
         valid_q <= 1'b0;
         epoch_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         addr_q  <= addr_d;
         v_q     <= v_d;
         z_q     <= z_d;
         chip_q  <= chip_d;
         valid_q <= valid_d;
         epoch_q <= epoch_d;
         err_q   <= err_d;
      end
   end
   assign pcode_addr = addr_q;
   assign chip_out   = chip_q;
   assign chip_valid = valid_q;
   assign epoch      = epoch_q;
   assign phase_err  = err_q;
endmodule
